// File: rtl/axi_m_wr_arbiter.sv
// Two-requester AXI write-channel arbiter with round-robin grant.
// One write transaction is in flight at a time; the owner's AW/W/B channels are muxed onto the bus.
module axi_m_wr_arbiter #(
    parameter int unsigned AW_WIDTH   = 32,
    parameter int unsigned LEN        = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                        axi_clk,
    input  logic                        rst,
    input  logic [1:0]                  s_awvalid,
    output logic [1:0]                  s_awready,
    input  logic [2*AW_WIDTH-1:0]       s_awaddr,
    input  logic [2*LEN-1:0]            s_awlen,
    input  logic [1:0]                  s_wvalid,
    output logic [1:0]                  s_wready,
    input  logic [2*DATA_WIDTH-1:0]     s_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic [1:0]                  s_wlast,
    output logic [1:0]                  s_bvalid,
    input  logic [1:0]                  s_bready,
    output logic [1:0]                  s_bresp,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [AW_WIDTH-1:0]         awaddr,
    output logic [LEN-1:0]              awlen,
    output logic                        wvalid,
    input  logic                        wready,
    output logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH/8-1:0]     wstrb,
    output logic                        wlast,
    input  logic                        bwvalid,
    output logic                        bwready,
    input  logic [1:0]                  bresp,
    output logic [1:0]                  grant,
    output logic                        wlast_err
);

    localparam int unsigned SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e         state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic [LEN-1:0] cnt_q, cnt_d;
    logic           last_q, last_d;
    logic           wlast_err_q, wlast_err_d;

    logic                  gidx;
    logic [AW_WIDTH-1:0]   g_awaddr;
    logic [LEN-1:0]        g_awlen;
    logic                  g_wvalid;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [SW-1:0]         g_wstrb;
    logic                  g_wlast;
    logic                  g_bready;
    logic                  beat;

    // grant_q is one-hot while busy, so bit 1 alone identifies the owner
    assign gidx     = grant_q[1];
    assign g_awaddr = gidx ? s_awaddr[2*AW_WIDTH-1:AW_WIDTH] : s_awaddr[AW_WIDTH-1:0];
    assign g_awlen  = gidx ? s_awlen[2*LEN-1:LEN] : s_awlen[LEN-1:0];
    assign g_wvalid = gidx ? s_wvalid[1] : s_wvalid[0];
    assign g_wdata  = gidx ? s_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_wdata[DATA_WIDTH-1:0];
    assign g_wstrb  = gidx ? s_wstrb[2*SW-1:SW] : s_wstrb[SW-1:0];
    assign g_wlast  = gidx ? s_wlast[1] : s_wlast[0];
    assign g_bready = gidx ? s_bready[1] : s_bready[0];
    assign beat     = (state_q == StData) && g_wvalid && wready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        wlast_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|s_awvalid) begin
                    state_d = StAddr;
                    if (&s_awvalid) begin
                        grant_d = last_q ? 2'b01 : 2'b10;
                    end else begin
                        grant_d = s_awvalid;
                    end
                end
            end
            StAddr: begin
                if (awready) begin
                    cnt_d   = g_awlen;
                    state_d = StData;
                end
            end
            StData: begin
                if (beat) begin
                    // The counter, not the requester's wlast, decides the end of the burst
                    wlast_err_d = g_wlast != (cnt_q == '0);
                    if (cnt_q == '0) begin
                        state_d = StResp;
                    end else begin
                        cnt_d = cnt_q - LEN'(1);
                    end
                end
            end
            StResp: begin
                if (bwvalid && g_bready) begin
                    last_d  = gidx;
                    grant_d = 2'b00;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axi_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            grant_q     <= 2'b00;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    always_comb begin
        awvalid   = (state_q == StAddr);
        awaddr    = g_awaddr;
        awlen     = g_awlen;
        s_awready = ((state_q == StAddr) && awready) ? grant_q : 2'b00;
        wvalid    = (state_q == StData) && g_wvalid;
        wdata     = g_wdata;
        wstrb     = g_wstrb;
        wlast     = (state_q == StData) && g_wlast;
        s_wready  = ((state_q == StData) && wready) ? grant_q : 2'b00;
        s_bvalid  = ((state_q == StResp) && bwvalid) ? grant_q : 2'b00;
        bwready   = (state_q == StResp) && g_bready;
        s_bresp   = bresp;
        grant     = grant_q;
        wlast_err = wlast_err_q;
    end

endmodule

// File: tb/tb_axi_m_wr_arbiter.sv
// Directed bench for axi_m_wr_arbiter: two requester models and a slave model stepped per cycle,
// with each scenario task checking its own hand-derived expectations.
module tb_axi_m_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_awvalid, s_awready;
    logic [63:0] s_awaddr;
    logic [15:0] s_awlen;
    logic [1:0]  s_wvalid, s_wready;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic [1:0]  s_wlast, s_bvalid, s_bready, s_bresp;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, bwvalid, bwready;
    logic [1:0]  bresp, grant;
    logic        wlast_err;

    axi_m_wr_arbiter #(.AW_WIDTH(32), .LEN(8), .DATA_WIDTH(32)) dut (
        .axi_clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bwvalid(bwvalid), .bwready(bwready), .bresp(bresp),
        .grant(grant), .wlast_err(wlast_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // requester models
    logic [1:0]  aw_pend;
    logic [31:0] req_addr [2];
    logic [7:0]  req_len [2];
    logic        auto_rep [2];
    logic        w_act [2];
    int          w_beat [2];
    int          extra_last [2];
    // slave model
    logic [7:0]  sl_len;
    int          sl_beats, sl_b_wait, b_delay, stall_left;
    logic        sl_b_pend;
    int          cur_owner, cyc;
    // observations
    int          done_log [$];
    logic [1:0]  first_grant, bvalid_seen;
    logic        first_grant_set, resp_seen;
    int          wlast_beats, wlast_idx, err_pulses, leaks, addr_errs, data_errs;
    int          beats_at_resp, stalled_cycles;
    int          aw_cycle [2];
    int          done_cycle [2];

    function automatic logic [31:0] pat(input int i, input int b);
        return 32'hA500_0000 ^ 32'(i << 16) ^ 32'(b);
    endfunction

    function automatic logic [3:0] strbp(input int i);
        return (i == 1) ? 4'hC : 4'h3;
    endfunction

    task automatic model_reset();
        rst = 1'b0;
        s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_wvalid = '0; s_wdata = '0;
        s_wstrb = '0; s_wlast = '0; s_bready = '0; awready = 1'b0; wready = 1'b0;
        bwvalid = 1'b0; bresp = 2'b00;
        aw_pend = 2'b00; sl_len = '0; sl_beats = 0; sl_b_wait = 0; sl_b_pend = 1'b0;
        b_delay = 0; stall_left = 0; cur_owner = -1; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i] = '0; req_len[i] = '0; auto_rep[i] = 1'b0; w_act[i] = 1'b0;
            w_beat[i] = 0; extra_last[i] = -1; aw_cycle[i] = -1; done_cycle[i] = -1;
        end
        done_log.delete();
        first_grant = 2'b00; first_grant_set = 1'b0; bvalid_seen = 2'b00; resp_seen = 1'b0;
        wlast_beats = 0; wlast_idx = -1; err_pulses = 0; leaks = 0; addr_errs = 0;
        data_errs = 0; beats_at_resp = -1; stalled_cycles = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive at negedge, observe 1 time unit later, advance models after posedge.
    task automatic step();
        logic [1:0] aw_acc, wb_inc, b_done;
        logic       bus_beat, stalled, b_hs;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            s_awvalid[i]         = aw_pend[i];
            s_awaddr[i*32 +: 32] = req_addr[i];
            s_awlen[i*8 +: 8]    = req_len[i];
            s_wvalid[i]          = w_act[i];
            s_wdata[i*32 +: 32]  = pat(i, w_beat[i]);
            s_wstrb[i*4 +: 4]    = strbp(i);
            s_wlast[i]           = w_act[i] && (w_beat[i] == int'(req_len[i]) ||
                                                w_beat[i] == extra_last[i]);
        end
        s_bready = 2'b11;
        awready  = 1'b1;
        wready   = (stall_left == 0);
        bwvalid  = sl_b_pend && (sl_b_wait == 0);
        bresp    = 2'b10;
        #1;
        if (((s_awready | s_wready | s_bvalid) & ~grant) != 2'b00) leaks++;
        if (wlast_err) err_pulses++;
        if (awvalid && !first_grant_set) begin
            first_grant = grant;
            first_grant_set = 1'b1;
        end
        if (awvalid && awready) begin
            cur_owner = s_awready[1] ? 1 : (s_awready[0] ? 0 : -1);
            if (cur_owner < 0) addr_errs++;
            else begin
                if (awaddr !== req_addr[cur_owner] || awlen !== req_len[cur_owner]) addr_errs++;
                aw_cycle[cur_owner] = cyc;
            end
            sl_len = awlen; sl_beats = 0; resp_seen = 1'b0;
        end
        bus_beat = wvalid && wready;
        stalled  = wvalid && !wready;
        if (bus_beat) begin
            if (cur_owner < 0) data_errs++;
            else if (wdata !== pat(cur_owner, sl_beats) || wstrb !== strbp(cur_owner))
                data_errs++;
            if (wlast) begin
                wlast_beats++;
                wlast_idx = sl_beats;
            end
        end
        if (stalled) stalled_cycles++;
        if (bwready && !resp_seen) begin
            resp_seen = 1'b1;
            beats_at_resp = sl_beats;
        end
        b_hs = bwvalid && bwready;
        if (b_hs) begin
            bvalid_seen = s_bvalid;
            if (s_bresp !== 2'b10) data_errs++;
        end
        for (int i = 0; i < 2; i++) begin
            aw_acc[i] = s_awvalid[i] && s_awready[i];
            wb_inc[i] = s_wvalid[i] && s_wready[i];
            b_done[i] = s_bvalid[i] && s_bready[i];
        end
        @(posedge clk);
        if (bus_beat) begin
            sl_beats++;
            if (sl_beats == int'(sl_len) + 1) begin
                sl_b_pend = 1'b1;
                sl_b_wait = b_delay;
            end
        end else if (sl_b_pend && !b_hs && sl_b_wait > 0) begin
            sl_b_wait--;
        end
        if (b_hs) sl_b_pend = 1'b0;
        if (stalled && stall_left > 0) stall_left--;
        for (int i = 0; i < 2; i++) begin
            if (aw_acc[i]) begin
                aw_pend[i] = 1'b0; w_act[i] = 1'b1; w_beat[i] = 0;
            end
            if (wb_inc[i]) begin
                w_beat[i]++;
                if (w_beat[i] > int'(req_len[i])) w_act[i] = 1'b0;
            end
            if (b_done[i]) begin
                done_log.push_back(i);
                done_cycle[i] = cyc;
                if (auto_rep[i]) begin
                    aw_pend[i] = 1'b1;
                    req_addr[i] = req_addr[i] + 32'h100;
                end
            end
        end
        cyc++;
    endtask

    task automatic run_until_done(input int n, input int budget, output logic to);
        int k = 0;
        while (done_log.size() < n && k < budget) begin
            step();
            k++;
        end
        to = (done_log.size() < n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        s_awvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11;
        awready = 1'b1; wready = 1'b1; bwvalid = 1'b1;
        #1;
        n_tests++;
        if (grant !== 2'b00) begin
            $display("FAIL reset_grant: got %b, expected 00", grant); n_fail++;
        end
        n_tests++;
        if ({awvalid, wvalid, bwready, wlast_err} !== 4'b0000) begin
            $display("FAIL reset_bus: got %b, expected 0000", {awvalid, wvalid, bwready, wlast_err});
            n_fail++;
        end
        n_tests++;
        if ({s_awready, s_wready, s_bvalid} !== 6'b0) begin
            $display("FAIL reset_slaves: got %b, expected 000000", {s_awready, s_wready, s_bvalid});
            n_fail++;
        end
    endtask

    task automatic test_single();
        logic to;
        model_reset();
        aw_pend[0] = 1'b1; req_addr[0] = 32'h1000_0040; req_len[0] = 8'd3; b_delay = 2;
        run_until_done(1, 60, to);
        @(negedge clk); #1;
        n_tests++;
        if (to) begin $display("FAIL single_timeout: got no B handshake, expected one"); n_fail++; end
        n_tests++;
        if (first_grant !== 2'b01) begin
            $display("FAIL single_grant: got %b, expected 01", first_grant); n_fail++;
        end
        n_tests++;
        if (sl_beats != 4) begin $display("FAIL single_beats: got %0d, expected 4", sl_beats); n_fail++; end
        n_tests++;
        if (wlast_beats != 1 || wlast_idx != 3) begin
            $display("FAIL single_wlast: got %0d beats at idx %0d, expected 1 at 3", wlast_beats, wlast_idx);
            n_fail++;
        end
        n_tests++;
        if (bvalid_seen !== 2'b01) begin
            $display("FAIL single_bvalid: got %b, expected 01", bvalid_seen); n_fail++;
        end
        n_tests++;
        if (grant !== 2'b00 || bwready !== 1'b0) begin
            $display("FAIL single_idle: got grant %b bwready %b, expected 00 0", grant, bwready); n_fail++;
        end
        n_tests++;
        if (leaks != 0 || addr_errs != 0 || data_errs != 0 || err_pulses != 0) begin
            $display("FAIL single_integrity: got leaks %0d addr %0d data %0d err %0d, expected 0",
                     leaks, addr_errs, data_errs, err_pulses);
            n_fail++;
        end
    endtask

    task automatic test_round_robin();
        logic to;
        int exp_order [4] = '{0, 1, 0, 1};
        model_reset();
        aw_pend = 2'b11; auto_rep[0] = 1'b1; auto_rep[1] = 1'b1;
        req_addr[0] = 32'h0000_2000; req_addr[1] = 32'h0000_3000;
        req_len[0] = 8'd1; req_len[1] = 8'd2; b_delay = 0;
        run_until_done(4, 100, to);
        n_tests++;
        if (to) begin $display("FAIL rr_timeout: got %0d completions, expected 4", done_log.size()); n_fail++; end
        for (int k = 0; k < 4 && k < done_log.size(); k++) begin
            n_tests++;
            if (done_log[k] != exp_order[k]) begin
                $display("FAIL rr_order[%0d]: got req%0d, expected req%0d", k, done_log[k], exp_order[k]);
                n_fail++;
            end
        end
        n_tests++;
        if (leaks != 0 || addr_errs != 0 || data_errs != 0) begin
            $display("FAIL rr_integrity: got leaks %0d addr %0d data %0d, expected 0",
                     leaks, addr_errs, data_errs);
            n_fail++;
        end
    endtask

    task automatic test_holdoff();
        logic to;
        int k = 0;
        model_reset();
        aw_pend[0] = 1'b1; req_addr[0] = 32'h0000_4000; req_len[0] = 8'd3; b_delay = 1;
        while (w_beat[0] < 1 && k < 40) begin step(); k++; end
        aw_pend[1] = 1'b1; req_addr[1] = 32'hBEEF_0080; req_len[1] = 8'd1;
        run_until_done(2, 60, to);
        n_tests++;
        if (to) begin $display("FAIL hold_timeout: got %0d completions, expected 2", done_log.size()); n_fail++; end
        n_tests++;
        if (done_log.size() != 2 || done_log[0] != 0 || done_log[1] != 1) begin
            $display("FAIL hold_order: got %0d completions, expected req0 then req1", done_log.size());
            n_fail++;
        end
        n_tests++;
        if (aw_cycle[1] <= done_cycle[0]) begin
            $display("FAIL hold_aw1: got AW1 at cycle %0d, expected after B0 at %0d",
                     aw_cycle[1], done_cycle[0]);
            n_fail++;
        end
        n_tests++;
        if (leaks != 0 || addr_errs != 0) begin
            $display("FAIL hold_integrity: got leaks %0d addr %0d, expected 0", leaks, addr_errs);
            n_fail++;
        end
    endtask

    task automatic test_wlast_err();
        logic to;
        model_reset();
        aw_pend[0] = 1'b1; req_addr[0] = 32'h0000_5000; req_len[0] = 8'd3; extra_last[0] = 1;
        b_delay = 1;
        run_until_done(1, 60, to);
        repeat (2) step();
        n_tests++;
        if (to) begin $display("FAIL werr_timeout: got no B handshake, expected one"); n_fail++; end
        n_tests++;
        if (err_pulses != 1) begin $display("FAIL werr_pulses: got %0d, expected 1", err_pulses); n_fail++; end
        n_tests++;
        if (beats_at_resp != 4) begin
            $display("FAIL werr_resp_entry: got %0d beats, expected 4", beats_at_resp); n_fail++;
        end
        n_tests++;
        if (sl_beats != 4) begin $display("FAIL werr_beats: got %0d, expected 4", sl_beats); n_fail++; end
    endtask

    task automatic test_abort();
        logic to;
        int k = 0;
        model_reset();
        aw_pend[0] = 1'b1; req_addr[0] = 32'h0000_6000; req_len[0] = 8'd7;
        while (sl_beats < 2 && k < 40) begin step(); k++; end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (grant !== 2'b00 || {awvalid, wvalid, bwready, wlast_err} !== 4'b0000) begin
            $display("FAIL abort_bus: got grant %b bus %b, expected 00 0000", grant,
                     {awvalid, wvalid, bwready, wlast_err});
            n_fail++;
        end
        n_tests++;
        if ({s_awready, s_wready, s_bvalid} !== 6'b0) begin
            $display("FAIL abort_slaves: got %b, expected 000000", {s_awready, s_wready, s_bvalid});
            n_fail++;
        end
        model_reset();
        aw_pend[1] = 1'b1; req_addr[1] = 32'h0000_7000; req_len[1] = 8'd2;
        run_until_done(1, 60, to);
        n_tests++;
        if (to || done_log.size() != 1 || done_log[0] != 1) begin
            $display("FAIL abort_recover: got %0d completions, expected one from req1", done_log.size());
            n_fail++;
        end
        n_tests++;
        if (first_grant !== 2'b10 || sl_beats != 3) begin
            $display("FAIL abort_fresh: got grant %b beats %0d, expected 10 3", first_grant, sl_beats);
            n_fail++;
        end
    endtask

    task automatic test_single_beat_stall();
        logic to;
        model_reset();
        aw_pend[0] = 1'b1; req_addr[0] = 32'h0000_8000; req_len[0] = 8'd0;
        stall_left = 3; b_delay = 1;
        run_until_done(1, 60, to);
        @(negedge clk); #1;
        n_tests++;
        if (to) begin $display("FAIL len0_timeout: got no B handshake, expected one"); n_fail++; end
        n_tests++;
        if (stalled_cycles != 3) begin
            $display("FAIL len0_stall: got %0d held cycles, expected 3", stalled_cycles); n_fail++;
        end
        n_tests++;
        if (sl_beats != 1 || wlast_idx != 0) begin
            $display("FAIL len0_beats: got %0d beats wlast idx %0d, expected 1 0", sl_beats, wlast_idx);
            n_fail++;
        end
        n_tests++;
        if (grant !== 2'b00) begin $display("FAIL len0_grant: got %b, expected 00", grant); n_fail++; end
        n_tests++;
        if (err_pulses != 0 || data_errs != 0) begin
            $display("FAIL len0_integrity: got err %0d data %0d, expected 0", err_pulses, data_errs);
            n_fail++;
        end
    endtask

    task automatic test_max_len();
        logic to;
        model_reset();
        aw_pend[1] = 1'b1; req_addr[1] = 32'h0000_9000; req_len[1] = 8'hFF;
        run_until_done(1, 400, to);
        n_tests++;
        if (to || sl_beats != 256) begin
            $display("FAIL maxlen_beats: got %0d beats, expected 256", sl_beats); n_fail++;
        end
        n_tests++;
        if (err_pulses != 0 || data_errs != 0 || wlast_idx != 255) begin
            $display("FAIL maxlen_integrity: got err %0d data %0d wlast idx %0d, expected 0 0 255",
                     err_pulses, data_errs, wlast_idx);
            n_fail++;
        end
    endtask

    initial begin
        rst = 1'b0;
        s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_wvalid = '0; s_wdata = '0;
        s_wstrb = '0; s_wlast = '0; s_bready = '0; awready = 1'b0; wready = 1'b0;
        bwvalid = 1'b0; bresp = 2'b00;
        test_reset();
        test_single();
        test_round_robin();
        test_holdoff();
        test_wlast_err();
        test_abort();
        test_single_beat_stall();
        test_max_len();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_m_wr_arbiter.md
AXI_M_WR_ARBITER -- requirements
Module: axi_m_wr_arbiter

Interface
REQ-001 The block SHALL declare parameter AW_WIDTH, default 32, address width.
REQ-002 The block SHALL declare parameter LEN, default 8, burst length field width.
REQ-003 The block SHALL declare parameter DATA_WIDTH, default 32, write data width; strobe width is DATA_WIDTH/8.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have these ports, one per line as name, direction, width, meaning; index i ∈ {0,1} selects slice i of each packed s_* vector:
- axi_clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- s_awvalid  in  2  requester write-address valid
- s_awready  out  2  requester write-address ready
- s_awaddr  in  2*AW_WIDTH  requester address
- s_awlen  in  2*LEN  requester burst length (beats-1)
- s_wvalid  in  2  requester write-data valid
- s_wready  out  2  requester write-data ready
- s_wdata  in  2*DATA_WIDTH  requester data
- s_wstrb  in  2*DATA_WIDTH/8  requester strobes
- s_wlast  in  2  requester last beat
- s_bvalid  out  2  requester response valid
- s_bready  in  2  requester response ready
- s_bresp  out  2  response code to requesters (same value on both slices)
- awvalid, awready, awaddr, awlen  out/in/out/out  1/1/AW_WIDTH/LEN  shared AXI address channel
- wvalid, wready, wdata, wstrb, wlast  out/in/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1  shared AXI data channel
- bwvalid, bwready, bresp  in/out/in  1/1/2  shared AXI response channel
- grant  out  2  one-hot owner of the bus; 0 when idle
- wlast_err  out  1  one-cycle pulse on a wlast/beat-count mismatch

Function
REQ-006 The block SHALL implement an FSM with states IDLE, ADDR, DATA, RESP; exactly one write transaction SHALL be outstanding at a time.
REQ-007 IDLE: when any s_awvalid is set, the block SHALL register the winner into grant and move to ADDR on the next edge, giving one cycle of arbitration latency.
REQ-008 Arbitration SHALL be round-robin: if both requesters are valid, the one not granted last wins; if only one is valid, it wins.
REQ-009 ADDR: awvalid SHALL be 1; awaddr and awlen SHALL be muxed from the granted slice; s_awready[g] SHALL equal awready combinationally.
REQ-010 ADDR: on awvalid&awready the block SHALL load beat counter = awlen and go to DATA.
REQ-011 DATA: wvalid, wdata, wstrb and wlast SHALL pass from the granted slice; s_wready[g] SHALL equal wready.
REQ-012 DATA: each wvalid&wready SHALL decrement the counter; the handshake made with counter==0 SHALL move the FSM to RESP.
REQ-013 wlast_err SHALL pulse when a handshaken beat has s_wlast[g] != (counter==0); the FSM SHALL still follow the counter.
REQ-014 RESP: s_bvalid[g] SHALL equal bwvalid, bwready SHALL equal s_bready[g], and s_bresp SHALL equal bresp.
REQ-015 RESP: on bwvalid&bwready the block SHALL record g as last-granted, clear grant and return to IDLE; a new arbitration can win in the following cycle.
REQ-016 Every s_* ready/valid output of the non-granted requester SHALL be 0 at all times; all shared-bus valid/ready outputs SHALL be 0 outside their state.
REQ-017 Requests arriving during a transaction SHALL be held off (s_awready=0) without loss until IDLE.
REQ-018 awlen=0 SHALL produce a single-beat burst; awlen=2^LEN-1 SHALL be counted without overflow.

Reset
REQ-019 While rst=0, the FSM SHALL be in IDLE, grant=0, the counter 0, last-granted=1 (so requester 0 wins first), and all valid/ready outputs and wlast_err 0.
REQ-020 Assertion of rst mid-transaction SHALL abort immediately to the reset state; no partial-burst recovery SHALL be attempted.

Verification
REQ-021 Single req0, awlen=3, awready/wready tied 1, bwvalid after 2 cycles -> grant=01, exactly 4 W beats, wlast on beat 4, s_bvalid[0]=1, back in IDLE.
REQ-022 Both requesters valid continuously from reset -> grants alternate 01,10,01,10 across 4 transactions.
REQ-023 req1 raises awvalid during req0's DATA phase -> s_awready[1]=0 until req0's B handshake; req1 is granted next with its address intact.
REQ-024 req0 asserts s_wlast on beat 2 of an awlen=3 burst -> wlast_err pulses once; the FSM enters RESP only after the 4th beat.
REQ-025 rst driven low in DATA after 2 of 8 beats -> all outputs 0 the same cycle; after release, a fresh req1-only transaction completes normally.
REQ-026 awlen=0 with wready stalled for 3 cycles -> wvalid is held; one beat is transferred; grant is cleared after the B handshake.
